rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 33 +++
 rtl/rr_arbiter8.sv | 110 +++++++++++
 tb/tb_rr_arbiter8.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Shared constants and state type for the 8-channel
//               round-robin arbiter and its circular find-first picker.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_pkg;

    localparam int NCH  = 8;    // number of request channels
    localparam int SELW = 3;    // width of a channel index
    localparam int CNTW = 4;    // width of the per-grant beat counter

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : rr_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational circular find-first. Returns the first index j
//               in the order ptr, ptr+1, ..., ptr+7 (mod 8) with req[j] set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import rr_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    // Walk the channels starting at ptr; the 3-bit add wraps 7 -> 0 for free.
    always_comb begin : p_find_first
        logic [SELW-1:0] v_j;
        idx   = '0;
        found = 1'b0;
        v_j   = '0;
        for (int k = 0; k < NCH; k++) begin
            v_j = ptr + SELW'(k);
            if (!found && req[v_j]) begin
                idx   = v_j;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-channel round-robin arbiter driving a mux8 select. Holds a
//               grant for up to BURST accepted beats, then hands over to the
//               next requester after the released channel, back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import rr_pkg::*;
#(
    parameter int BURST = 1     // max consecutive accepted beats per grant (1..16)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  req,
    input  logic            ready,
    output logic [SELW-1:0] select,
    output logic            valid,
    output logic [NCH-1:0]  grant
);

    localparam logic [CNTW-1:0] c_BURST_LAST = CNTW'(BURST - 1);

    state_e          r_state_q, w_state_d;
    logic [SELW-1:0] r_sel_q,   w_sel_d;
    logic [SELW-1:0] r_ptr_q,   w_ptr_d;
    logic [CNTW-1:0] r_cnt_q,   w_cnt_d;

    logic [NCH-1:0]  w_sel_onehot;
    logic [NCH-1:0]  w_pick_req;
    logic [SELW-1:0] w_pick_ptr;
    logic [SELW-1:0] w_pick_idx;
    logic            w_pick_found;
    logic            w_xfer;
    logic            w_last;

    assign w_sel_onehot = {{(NCH-1){1'b0}}, 1'b1} << r_sel_q;
    assign w_xfer       = valid && ready;
    assign w_last       = (r_cnt_q >= c_BURST_LAST);

    // In IDLE the picker searches the raw request from the stored pointer;
    // in GRANT it is only consulted on release, so it searches from the
    // channel after the current one with that channel masked off.
    assign w_pick_req = (r_state_q == GRANT) ? (req & ~w_sel_onehot) : req;
    assign w_pick_ptr = (r_state_q == GRANT) ? (r_sel_q + SELW'(1)) : r_ptr_q;

    rr_pick8 u_pick (
        .req   (w_pick_req),
        .ptr   (w_pick_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // Outputs are a direct decode of the registered state and select.
    assign valid  = (r_state_q == GRANT);
    assign select = r_sel_q;
    assign grant  = valid ? w_sel_onehot : '0;

    // Next-state logic: hold everything unless a grant starts, a beat is
    // accepted, or the grant is released.
    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            IDLE: begin
                if (|req) begin
                    w_state_d = GRANT;
                    w_sel_d   = w_pick_idx;
                    w_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    if (req[r_sel_q] && !w_last) begin
                        w_cnt_d = r_cnt_q + CNTW'(1);
                    end else begin
                        w_ptr_d = r_sel_q + SELW'(1);
                        if (w_pick_found) begin
                            w_sel_d = w_pick_idx;
                            w_cnt_d = '0;
                        end else begin
                            w_state_d = IDLE;
                        end
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_sel_q   <= '0;
            r_ptr_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_ptr_q   <= w_ptr_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Self-checking bench for rr_arbiter8. Two instances (BURST=1
//               and BURST=3) share stimulus and are compared every cycle
//               against a behavioural round-robin model, plus directed
//               scenario checks against fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       ready;

    logic [2:0] sel0, sel1;
    logic       val0, val1;
    logic [7:0] gnt0, gnt1;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state per instance
    int m_valid [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_burst [2];

    always #5 clk = ~clk;

    rr_arbiter8 #(.BURST(1)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .select(sel0), .valid(val0), .grant(gnt0)
    );

    rr_arbiter8 #(.BURST(3)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .select(sel1), .valid(val1), .grant(gnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // First requesting channel in circular order starting at p, or -1.
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // Advance one instance's model by one clock using the current inputs.
    task automatic model_step(input int m);
        int masked_pick;
        logic [7:0] masked;
        if (reset) begin
            m_valid[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
        end else if (m_valid[m] == 0) begin
            if (req != 8'h00) begin
                m_valid[m] = 1;
                m_sel[m]   = pick(req, m_ptr[m]);
                m_cnt[m]   = 0;
            end
        end else if (ready) begin
            if (req[m_sel[m]] && (m_cnt[m] < m_burst[m] - 1)) begin
                m_cnt[m] = m_cnt[m] + 1;
            end else begin
                m_ptr[m]    = (m_sel[m] + 1) % 8;
                masked      = req & ~(8'h01 << m_sel[m]);
                masked_pick = pick(masked, m_ptr[m]);
                if (masked_pick >= 0) begin
                    m_sel[m] = masked_pick;
                    m_cnt[m] = 0;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_grant(input int m);
        return (m_valid[m] != 0) ? (8'h01 << m_sel[m]) : 8'h00;
    endfunction

    // Apply inputs, clock once, then compare both instances with the model.
    task automatic cyc(input logic [7:0] r, input logic rdy, input logic rst);
        req   = r;
        ready = rdy;
        reset = rst;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk("d0.valid",  32'(val0), 32'(m_valid[0]));
        chk("d0.select", 32'(sel0), 32'(m_sel[0]));
        chk("d0.grant",  32'(gnt0), 32'(exp_grant(0)));
        chk("d1.valid",  32'(val1), 32'(m_valid[1]));
        chk("d1.select", 32'(sel1), 32'(m_sel[1]));
        chk("d1.grant",  32'(gnt1), 32'(exp_grant(1)));
    endtask

    initial begin
        m_burst[0] = 1;
        m_burst[1] = 3;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
        end
        req   = 8'h00;
        ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Reset with all channels requesting and ready high
        cyc(8'hFF, 1'b1, 1'b1);
        cyc(8'hFF, 1'b1, 1'b1);
        chk("rst.valid",  32'(val0), 32'd0);
        chk("rst.grant",  32'(gnt0), 32'h00);
        chk("rst.select", 32'(sel0), 32'd0);

        // Full rotation 0..7,0 with valid held high (BURST=1)
        for (int i = 0; i < 9; i++) begin
            cyc(8'hFF, 1'b1, 1'b0);
            chk("rot.select", 32'(sel0), 32'(i % 8));
            chk("rot.valid",  32'(val0), 32'd1);
        end

        // Lone requester: one-cycle latency, then 1,0,1,0 bubble pattern
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h04, 1'b1, 1'b0);
        chk("lone.valid",  32'(val0), 32'd1);
        chk("lone.select", 32'(sel0), 32'd2);
        chk("lone.grant",  32'(gnt0), 32'h04);
        cyc(8'h04, 1'b1, 1'b0);
        chk("lone.bubble0", 32'(val0), 32'd0);
        cyc(8'h04, 1'b1, 1'b0);
        chk("lone.regrant", 32'(val0), 32'd1);
        cyc(8'h04, 1'b1, 1'b0);
        chk("lone.bubble1", 32'(val0), 32'd0);

        // Stall on channel 3 while request moves to channel 7
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h08, 1'b0, 1'b0);
        chk("stall.start", 32'(sel0), 32'd3);
        for (int i = 0; i < 5; i++) begin
            cyc(8'h80, 1'b0, 1'b0);
            chk("stall.select", 32'(sel0), 32'd3);
            chk("stall.grant",  32'(gnt0), 32'h08);
        end
        cyc(8'h80, 1'b1, 1'b0);
        chk("stall.handover", 32'(sel0), 32'd7);

        // BURST=3 with channels 0 and 4: 0,0,0,4,4,4,0
        cyc(8'h00, 1'b0, 1'b1);
        begin
            int exp_seq [7] = '{0, 0, 0, 4, 4, 4, 0};
            for (int i = 0; i < 7; i++) begin
                cyc(8'h11, 1'b1, 1'b0);
                chk("burst.select", 32'(sel1), 32'(exp_seq[i]));
                chk("burst.valid",  32'(val1), 32'd1);
            end
        end

        // Pointer wrap: release of channel 7 with req 0x81 goes to 0
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h80, 1'b1, 1'b0);
        chk("wrap.start", 32'(sel0), 32'd7);
        cyc(8'h81, 1'b1, 1'b0);
        chk("wrap.select", 32'(sel0), 32'd0);
        chk("wrap.valid",  32'(val0), 32'd1);

        // Reset during a grant on channel 5, then regrant
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h20, 1'b0, 1'b0);
        chk("midrst.start", 32'(sel0), 32'd5);
        cyc(8'h20, 1'b1, 1'b1);
        chk("midrst.valid", 32'(val0), 32'd0);
        chk("midrst.grant", 32'(gnt0), 32'h00);
        cyc(8'h20, 1'b1, 1'b0);
        chk("midrst.regrant", 32'(sel0), 32'd5);
        chk("midrst.revalid", 32'(val0), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            if (i % 2 == 0) r = 8'($urandom_range(0, 255));
            else            r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            cyc(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr_arbiter8
`default_nettype wire
